// File: rtl/axis_selector_n.sv
// N-input AXI-Stream selector: a select stream steers one data channel into a
// single registered output slot; out-of-range selects are dropped and counted.
module axis_selector_n #(
  parameter int CHANNELS           = 4,
  parameter int DATA_WIDTH         = 16,
  parameter int SEL_WIDTH          = 2,
  parameter int DISCARD_UNSELECTED = 0,
  parameter int COUNT_WIDTH        = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS-1:0]            input_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] input_data,
  output logic [CHANNELS-1:0]            input_ready,
  input  logic                           select_valid,
  input  logic [SEL_WIDTH-1:0]           select_data,
  output logic                           select_ready,
  output logic                           output_valid,
  output logic [DATA_WIDTH-1:0]          output_data,
  input  logic                           output_ready,
  output logic [COUNT_WIDTH-1:0]         drop_count
);

  // One extra bit so CHANNELS == 2**SEL_WIDTH is representable.
  localparam logic [SEL_WIDTH:0] CH_L = (SEL_WIDTH+1)'(CHANNELS);

  logic                   r_valid;
  logic [DATA_WIDTH-1:0]  r_data;
  logic [COUNT_WIDTH-1:0] r_cnt;

  logic                  w_in_range;
  logic                  w_slot_free;
  logic                  w_sel_valid;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_go;
  logic                  w_load;
  logic                  w_drop;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (select_data == SEL_WIDTH'(i)) begin
        w_sel_valid = input_valid[i];
        w_sel_data  = input_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_in_range  = {1'b0, select_data} < CH_L;
  assign w_slot_free = !r_valid || output_ready;

  // Out-of-range selects in mode 0 never touch the output slot, so they
  // bypass backpressure entirely.
  always_comb begin
    w_go = 1'b0;
    if (!rst && select_valid) begin
      if (DISCARD_UNSELECTED != 0) w_go = (&input_valid) && w_slot_free;
      else if (w_in_range)         w_go = w_sel_valid && w_slot_free;
      else                         w_go = 1'b1;
    end
  end

  assign w_load       = w_go && w_in_range;
  assign w_drop       = w_go && !w_in_range;
  assign select_ready = w_go;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_rdy
    if (DISCARD_UNSELECTED != 0) begin : g_all
      assign input_ready[i] = w_go;
    end else begin : g_one
      assign input_ready[i] = w_load && (select_data == SEL_WIDTH'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_sel_data;
      end else if (r_valid && output_ready) begin
        r_valid <= 1'b0;
      end
      if (w_drop && r_cnt != '1) r_cnt <= r_cnt + COUNT_WIDTH'(1);
    end
  end

  assign output_valid = r_valid;
  assign output_data  = r_data;
  assign drop_count   = r_cnt;

endmodule
